// File: rtl/hough_stream_pkg.sv
// Shared definitions for the Hough block and its pixel stream handlers.
//   PIXEL_W        : width of one grey-scale pixel
//   pixel_t        : one pixel
//   stream_state_e : raster sequencer state encoding
package hough_stream_pkg;

    localparam int PIXEL_W = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } stream_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous single-clock pixel FIFO with occupancy count.
//   clk_i     : clock, rising edge
//   rst_ni    : synchronous active-low reset, empties the FIFO
//   wr_en_i   : write request, ignored while full
//   wr_data_i : pixel to write
//   rd_en_i   : read request, ignored while empty
//   rd_data_o : head of the FIFO (valid when count_o > 0)
//   full_o    : FIFO holds DEPTH entries
//   count_o   : number of stored entries
module pixel_fifo
    import hough_stream_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_i,
    input  pixel_t                     wr_data_i,
    input  logic                       rd_en_i,
    output pixel_t                     rd_data_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pixel_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, empty;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = wr_en_i & ~full_o;
    assign pop       = rd_en_i & ~empty;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Explicit wrap so non power-of-two depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (int'(wr_ptr_q) == DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (int'(rd_ptr_q) == DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// Buffered raster pixel transmitter.
// Pixels written on the input side are buffered and replayed as a raster of
// IMG_H lines of IMG_W pixels, with H_BLANK idle cycles after each line and
// V_BLANK idle cycles after the last line of a frame. A line only starts once
// a whole line is buffered, so a line never underruns.
//   Clk     : clock, rising edge
//   nReset  : synchronous active-low reset
//   InPixel : pixel to write
//   InValid : InPixel offered
//   InReady : buffer not full
//   Pixel   : stream pixel, 0 when not Active
//   Frame   : strobe on pixel (0,0)
//   Line    : strobe on column 0 of every line
//   Active  : Pixel carries image data
module pixel_stream_tx
    import hough_stream_pkg::*;
#(
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 128,
    parameter int H_BLANK    = 4,
    parameter int V_BLANK    = 16,
    parameter int FIFO_DEPTH = 256
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic [PIXEL_W-1:0] InPixel,
    input  logic               InValid,
    output logic               InReady,
    output logic [PIXEL_W-1:0] Pixel,
    output logic               Frame,
    output logic               Line,
    output logic               Active
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BLK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BLK_W   = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;

    stream_state_e    state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [BLK_W-1:0] blk_q, blk_d;

    logic [CNT_W-1:0] fifo_cnt;
    pixel_t           fifo_head;
    logic             fifo_full;
    logic             line_ready;
    logic             pop;

    pixel_t           pixel_d, pixel_q;
    logic             active_d, active_q;
    logic             line_d, line_q;
    logic             frame_d, frame_q;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (Clk),
        .rst_ni    (nReset),
        .wr_en_i   (InValid),
        .wr_data_i (InPixel),
        .rd_en_i   (pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .count_o   (fifo_cnt)
    );

    assign InReady    = ~fifo_full;
    assign line_ready = (int'(fifo_cnt) >= IMG_W);

    // State register. state_q/col_q/row_q describe the pixel currently on
    // the registered outputs, so state_q==ST_ACTIVE coincides with Active.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q  <= ST_WAIT;
            col_q    <= '0;
            row_q    <= '0;
            blk_q    <= '0;
            pixel_q  <= '0;
            active_q <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            blk_q    <= blk_d;
            pixel_q  <= pixel_d;
            active_q <= active_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        blk_d   = blk_q;
        case (state_q)
            ST_WAIT: begin
                if (line_ready) begin
                    state_d = ST_ACTIVE;
                    col_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (int'(col_q) == IMG_W - 1) begin
                    col_d = '0;
                    blk_d = '0;
                    if (int'(row_q) == IMG_H - 1) begin
                        row_d   = '0;
                        state_d = (V_BLANK == 0) ? ST_WAIT : ST_VBLANK;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = (H_BLANK == 0) ? ST_WAIT : ST_HBLANK;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            // At the end of a blank the WAIT check is folded in: if the next
            // line is already buffered it starts immediately, so the idle gap
            // is exactly the blank length.
            ST_HBLANK: begin
                if (int'(blk_q) == H_BLANK - 1) begin
                    blk_d   = '0;
                    state_d = line_ready ? ST_ACTIVE : ST_WAIT;
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end
            ST_VBLANK: begin
                if (int'(blk_q) == V_BLANK - 1) begin
                    blk_d   = '0;
                    state_d = line_ready ? ST_ACTIVE : ST_WAIT;
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Output decode from the next state: the FIFO head is popped on the same
    // edge that loads it into the output register.
    always_comb begin
        pop      = (state_d == ST_ACTIVE);
        active_d = pop;
        pixel_d  = pop ? fifo_head : '0;
        line_d   = pop && (col_d == '0);
        frame_d  = line_d && (row_d == '0);
    end

    assign Pixel  = pixel_q;
    assign Active = active_q;
    assign Line   = line_q;
    assign Frame  = frame_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: accepted writes go into a scoreboard queue and
// are compared in order against every Active output pixel; Line/Frame are
// checked against an independent raster position model, InReady against an
// occupancy model.
module tb_pixel_stream_tx;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 3;
    localparam int H_BLANK = 2;
    localparam int V_BLANK = 3;
    localparam int DEPTH   = 8;

    logic       Clk     = 1'b0;
    logic       nReset  = 1'b0;
    logic       InValid = 1'b0;
    logic [7:0] InPixel = '0;
    logic       InReady;
    logic [7:0] Pixel;
    logic       Frame, Line, Active;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb [$];
    int         m_col = 0, m_row = 0, m_cnt = 0, frames_seen = 0;
    bit         mon_en = 1'b0;

    always #5 Clk = ~Clk;

    pixel_stream_tx #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .H_BLANK    (H_BLANK),
        .V_BLANK    (V_BLANK),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk     (Clk),
        .nReset  (nReset),
        .InPixel (InPixel),
        .InValid (InValid),
        .InReady (InReady),
        .Pixel   (Pixel),
        .Frame   (Frame),
        .Line    (Line),
        .Active  (Active)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pop and raster position model.
    always @(negedge Clk) begin
        logic [31:0] exp;
        if (mon_en) begin
            if (Active) begin
                exp = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hDEAD_BEEF;
                chk("pixel", {24'd0, Pixel}, exp);
                chk("line", Line, m_col == 0);
                chk("frame", Frame, (m_col == 0) && (m_row == 0));
                if (Frame) frames_seen++;
                if (m_col == IMG_W - 1) begin
                    m_col = 0;
                    m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end else begin
                chk("idle", {Pixel, Frame, Line}, 0);
            end
        end
    end

    // One clock cycle, called at a negedge: drive, check InReady against the
    // occupancy model, return whether the write was accepted and Active after.
    task automatic step(input bit v, input logic [7:0] p, output bit acc, output bit act);
        if (nReset) chk("inready", InReady, m_cnt < DEPTH);
        acc = v && (InReady === 1'b1) && nReset;
        InValid = v;
        InPixel = p;
        if (acc) sb.push_back(p);
        @(posedge Clk);
        @(negedge Clk);
        act = (Active === 1'b1);
        if (!nReset) m_cnt = 0;
        else         m_cnt = m_cnt + int'(acc) - int'(act);
    endtask

    task automatic do_reset();
        bit a, b;
        nReset = 1'b0;
        step(1'b0, 8'd0, a, b);
        sb.delete();
        m_col = 0;
        m_row = 0;
        m_cnt = 0;
        chk("rst_out", {Pixel, Frame, Line, Active}, 0);
        chk("rst_rdy", InReady, 1);
        nReset = 1'b1;
    endtask

    initial begin
        bit          acc, act, any;
        logic [23:0] v;
        int          f0, tries;

        @(negedge Clk);
        do_reset();
        mon_en = 1'b1;

        // 12 back-to-back pixels: three lines, 2-cycle H gap, 3-cycle V gap.
        v = '0;
        for (int i = 0; i < 24; i++) begin
            step(i < 12, 8'(i + 1), acc, act);
            v = {v[22:0], act};
        end
        chk("s1_active_pat", v, 24'b0000_1111_0011_1100_1111_0000);
        chk("s1_drain", sb.size(), 0);

        // 3 writes, long pause, 4th write: one-cycle start latency.
        do_reset();
        any = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step(i < 3, 8'(8'h21 + i), acc, act);
            any |= act;
        end
        chk("s2_early", any, 0);
        v = '0;
        step(1'b1, 8'h24, acc, act);
        v = {v[22:0], act};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'd0, acc, act);
            v = {v[22:0], act};
        end
        chk("s2_active_pat", v[5:0], 6'b011110);
        chk("s2_drain", sb.size(), 0);

        // InValid held high regardless of InReady: FIFO fills, drops ignored.
        do_reset();
        any = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 8'(100 + i), acc, act);
            if (!acc) any = 1'b1;
        end
        chk("s3_rdy_low", any, 1);
        for (int i = 0; i < 40; i++) step(1'b0, 8'd0, acc, act);
        chk("s3_drain", sb.size(), 0);

        // 1..24 with handshake across two frames; push/pop overlap in ACTIVE.
        do_reset();
        f0 = frames_seen;
        for (int p = 1; p <= 24; p++) begin
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 20) begin
                step(1'b1, 8'(p), acc, act);
                tries++;
            end
            chk("s4_wr_accept", acc, 1);
        end
        for (int i = 0; i < 40; i++) step(1'b0, 8'd0, acc, act);
        chk("s4_drain", sb.size(), 0);
        chk("s4_frames", frames_seen - f0, 2);

        // Reset at col 2 of row 1 aborts the frame.
        do_reset();
        for (int i = 0; i < 13; i++) step(i < 8, 8'(50 + i), acc, act);
        chk("s5_col2_pixel", {24'd0, Pixel}, 32'd56);
        do_reset();
        f0 = frames_seen;
        for (int i = 0; i < 12; i++) step(i < 4, 8'(60 + i), acc, act);
        chk("s5_frames", frames_seen - f0, 1);
        chk("s5_drain", sb.size(), 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
